tia_audio_poly_gen: RTL

Parametrised multi-channel TIA-style audio tone/noise generator, successor to the single 9-bit noise shift register. Per channel it holds AUDC/AUDF/AUDV registers, a 5-bit frequency divider and independent poly4/poly5/poly9 LFSRs plus div3/div31 prescalers, selected by a 16-entry mode table. Output is a per-channel volume-gated sample and a registered mix, feeding the audio DAC path.

---
 rtl/tia_audio_pkg.sv | 63 ++++++
 rtl/tia_audio_voice.sv | 94 +++++++++
 rtl/tia_audio_poly_gen.sv | 57 +++++
 3 files changed

// File: rtl/tia_audio_pkg.sv
// Shared constants and the AUDC mode decoder for the TIA-style audio generator.
// The mode decoder maps the 16 AUDC codes onto a waveform source and a step rate.
package tia_audio_pkg;

    localparam logic [3:0] MODE_SET1       = 4'd0;
    localparam logic [3:0] MODE_POLY4      = 4'd1;
    localparam logic [3:0] MODE_POLY5      = 4'd2;
    localparam logic [3:0] MODE_POLY9      = 4'd3;
    localparam logic [3:0] MODE_DIV2       = 4'd4;
    localparam logic [3:0] MODE_DIV31      = 4'd6;
    localparam logic [3:0] MODE_DIV6       = 4'd12;
    localparam logic [3:0] MODE_DIV93      = 4'd14;
    localparam logic [3:0] MODE_POLY5_DIV3 = 4'd15;

    localparam logic [1:0] ADDR_AUDC = 2'd0;
    localparam logic [1:0] ADDR_AUDF = 2'd1;
    localparam logic [1:0] ADDR_AUDV = 2'd2;
    localparam logic [1:0] ADDR_RSVD = 2'd3;

    localparam logic [3:0] POLY4_SEED = 4'hF;
    localparam logic [4:0] POLY5_SEED = 5'h1F;
    localparam logic [8:0] POLY9_SEED = 9'h1FF;

    typedef enum logic [2:0] {
        STEP_CYCLE,
        STEP_FREQ,
        STEP_DIV3,
        STEP_DIV31,
        STEP_DIV93
    } step_sel_e;

    typedef struct packed {
        logic      use_poly4;
        logic      use_poly5;
        logic      use_poly9;
        logic      toggle;
        step_sel_e step_sel;
    } mode_dec_t;

    // Modes that select neither a poly nor toggle force ch_bit high on their step.
    function automatic mode_dec_t mode_decode(input logic [3:0] audc);
        mode_dec_t d;
        d.use_poly4 = 1'b0;
        d.use_poly5 = 1'b0;
        d.use_poly9 = 1'b0;
        d.toggle    = 1'b0;
        d.step_sel  = STEP_CYCLE;
        case (audc)
            MODE_SET1, 4'd11:        d.step_sel = STEP_CYCLE;
            MODE_POLY4:              begin d.use_poly4 = 1'b1; d.step_sel = STEP_FREQ; end
            MODE_POLY5, 4'd7, 4'd9:  begin d.use_poly5 = 1'b1; d.step_sel = STEP_FREQ; end
            MODE_POLY9, 4'd8:        begin d.use_poly9 = 1'b1; d.step_sel = STEP_FREQ; end
            MODE_DIV2, 4'd5:         begin d.toggle = 1'b1; d.step_sel = STEP_FREQ; end
            MODE_DIV31, 4'd10:       begin d.toggle = 1'b1; d.step_sel = STEP_DIV31; end
            MODE_DIV6, 4'd13:        begin d.toggle = 1'b1; d.step_sel = STEP_DIV3; end
            MODE_DIV93:              begin d.toggle = 1'b1; d.step_sel = STEP_DIV93; end
            MODE_POLY5_DIV3:         begin d.use_poly5 = 1'b1; d.step_sel = STEP_DIV3; end
            default:                 d.step_sel = STEP_CYCLE;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/tia_audio_voice.sv
// One audio channel: AUDC/AUDF/AUDV registers, frequency divider, prescalers,
// poly4/5/9 LFSRs, the registered waveform bit and its volume-gated sample.
module tia_audio_voice
    import tia_audio_pkg::*;
#(
    parameter int FREQ_W = 5,
    parameter int VOL_W  = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             aud_tick,
    input  logic             wr_en,
    input  logic [1:0]       wr_addr,
    input  logic [4:0]       wr_data,
    output logic             ch_bit,
    output logic [VOL_W-1:0] ch_sample
);

    logic [3:0]        audc;
    logic [FREQ_W-1:0] audf;
    logic [VOL_W-1:0]  audv;
    logic [FREQ_W-1:0] freq_cnt;
    logic [1:0]        div3;
    logic [4:0]        div31;
    logic [3:0]        poly4;
    logic [4:0]        poly5;
    logic [8:0]        poly9;

    mode_dec_t dec;
    logic      freq_tick;
    logic      step31;
    logic      div3_adv;
    logic      step3;
    logic      step;

    // In mode 14 div3 counts step31 pulses, so its wrap becomes the div93 step.
    always_comb begin
        dec       = mode_decode(audc);
        freq_tick = aud_tick && (freq_cnt >= audf);
        step31    = freq_tick && (div31 == 5'd30);
        div3_adv  = (dec.step_sel == STEP_DIV93) ? step31 : freq_tick;
        step3     = div3_adv && (div3 == 2'd2);
        case (dec.step_sel)
            STEP_CYCLE:            step = 1'b1;
            STEP_FREQ:             step = freq_tick;
            STEP_DIV3, STEP_DIV93: step = step3;
            STEP_DIV31:            step = step31;
            default:               step = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            audc      <= '0;
            audf      <= '0;
            audv      <= '0;
            freq_cnt  <= '0;
            div3      <= '0;
            div31     <= '0;
            poly4     <= POLY4_SEED;
            poly5     <= POLY5_SEED;
            poly9     <= POLY9_SEED;
            ch_bit    <= 1'b0;
            ch_sample <= '0;
        end else begin
            if (wr_en) begin
                case (wr_addr)
                    ADDR_AUDC: audc <= wr_data[3:0];
                    ADDR_AUDF: audf <= wr_data[FREQ_W-1:0];
                    ADDR_AUDV: audv <= wr_data[VOL_W-1:0];
                    default:   ;
                endcase
            end
            if (aud_tick)  freq_cnt <= freq_tick ? '0 : freq_cnt + 1'b1;
            if (freq_tick) div31 <= (div31 == 5'd30) ? '0 : div31 + 1'b1;
            if (div3_adv)  div3 <= (div3 == 2'd2) ? '0 : div3 + 1'b1;

            // Each LFSR only moves when the active mode actually draws from it.
            if (step && dec.use_poly4) poly4 <= {poly4[0] ^ poly4[1], poly4[3:1]};
            if (step && dec.use_poly5) poly5 <= {poly5[0] ^ poly5[2], poly5[4:1]};
            if (step && dec.use_poly9) poly9 <= {poly9[0] ^ poly9[4], poly9[8:1]};

            if (step) begin
                if (dec.toggle)         ch_bit <= ~ch_bit;
                else if (dec.use_poly4) ch_bit <= poly4[0];
                else if (dec.use_poly5) ch_bit <= poly5[0];
                else if (dec.use_poly9) ch_bit <= poly9[0];
                else                    ch_bit <= 1'b1;
            end
            ch_sample <= ch_bit ? audv : '0;
        end
    end

endmodule

// File: rtl/tia_audio_poly_gen.sv
// Multi-channel TIA-style tone/noise generator: per-channel write decode,
// NUM_CH voice instances and a registered sum of the channel samples.
module tia_audio_poly_gen
    import tia_audio_pkg::*;
#(
    parameter int  NUM_CH = 2,
    parameter int  FREQ_W = 5,
    parameter int  VOL_W  = 4,
    localparam int MIX_W  = VOL_W + $clog2(NUM_CH + 1)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    aud_tick,
    input  logic                    wr_en,
    input  logic [1:0]              wr_ch,
    input  logic [1:0]              wr_addr,
    input  logic [4:0]              wr_data,
    output logic [NUM_CH-1:0]       ch_bit,
    output logic [NUM_CH*VOL_W-1:0] ch_sample,
    output logic [MIX_W-1:0]        mix_out
);

    logic [MIX_W-1:0] mix_sum;

    // Writes to a channel index with no voice, or to the reserved address, match nothing.
    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        logic ch_wr;
        assign ch_wr = wr_en && (wr_ch == 2'(g)) && (wr_addr != ADDR_RSVD);

        tia_audio_voice #(
            .FREQ_W(FREQ_W),
            .VOL_W (VOL_W)
        ) u_voice (
            .clk      (clk),
            .rst_n    (rst_n),
            .aud_tick (aud_tick),
            .wr_en    (ch_wr),
            .wr_addr  (wr_addr),
            .wr_data  (wr_data),
            .ch_bit   (ch_bit[g]),
            .ch_sample(ch_sample[g*VOL_W +: VOL_W])
        );
    end

    always_comb begin
        mix_sum = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            mix_sum = mix_sum + MIX_W'(ch_sample[i*VOL_W +: VOL_W]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) mix_out <= '0;
        else        mix_out <= mix_sum;
    end

endmodule
